// File: rtl/unary_gen_mc_if.sv
`default_nettype none
// ============================================================================
// Module  : unary_gen_mc_if
// Brief   : Frame handshake and stream bundle for unary_gen_mc. The ones_cnt
//           member exists only when ONES_COUNT_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
interface unary_gen_mc_if #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 10,
  parameter int CH     = 4
);
  logic                   start;
  logic [CH*DATA_W-1:0]   scalars;
  logic                   mode;
  logic                   busy;
  logic                   u_valid;
  logic [CH-1:0]          u_out;
  logic [LEN_W-1:0]       out_count;
  logic                   done;
`ifdef ONES_COUNT_EN
  logic [CH*(LEN_W+1)-1:0] ones_cnt;

  modport master (output start, scalars, mode,
                  input  busy, u_valid, u_out, out_count, done, ones_cnt);
  modport slave  (input  start, scalars, mode,
                  output busy, u_valid, u_out, out_count, done, ones_cnt);
`else
  modport master (output start, scalars, mode,
                  input  busy, u_valid, u_out, out_count, done);
  modport slave  (input  start, scalars, mode,
                  output busy, u_valid, u_out, out_count, done);
`endif
endinterface
`default_nettype wire

// File: rtl/unary_gen_mc.sv
`default_nettype none
// ============================================================================
// Module  : unary_gen_mc
// Brief   : CH-channel unary bitstream generator, 2^LEN_W bits per frame,
//           thermometer or bit-reversed ordering. Define ONES_COUNT_EN to add
//           per-channel ones counters on bus.ones_cnt.
// Revision: 1.0 - initial release
// ============================================================================
module unary_gen_mc #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 10,
  parameter int CH     = 4
) (
  input  wire logic        clk,
  input  wire logic        reset,
  unary_gen_mc_if.slave    bus
);

  localparam int               c_SHIFT   = LEN_W - DATA_W;
  localparam logic [LEN_W-1:0] c_CNT_MAX = '1;
  localparam logic [LEN_W-1:0] c_CNT_ONE = LEN_W'(1);

  generate
    if (LEN_W < DATA_W) begin : g_bad_len
      $error("unary_gen_mc: LEN_W must be >= DATA_W");
    end
    if (CH < 1) begin : g_bad_ch
      $error("unary_gen_mc: CH must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_LAST = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic [LEN_W-1:0] r_count;
  logic [LEN_W-1:0] w_count_rev;
  logic [LEN_W-1:0] w_cmp;
  logic             r_mode;
  logic [LEN_W-1:0] r_thr    [CH];
  logic [LEN_W-1:0] w_thr_in [CH];
  logic [CH-1:0]    w_bits;
  logic [CH-1:0]    r_u_out;
  logic [LEN_W-1:0] r_out_count;
  logic             r_u_valid;
  logic             r_done;

  generate
    for (genvar b = 0; b < LEN_W; b++) begin : g_rev
      assign w_count_rev[b] = r_count[LEN_W-1-b];
    end
  endgenerate

  assign w_cmp = r_mode ? w_count_rev : r_count;

  // Scalar is placed in the top DATA_W bits of the threshold.
  generate
    for (genvar i = 0; i < CH; i++) begin : g_ch
      assign w_thr_in[i] = LEN_W'(bus.scalars[i*DATA_W +: DATA_W]) << c_SHIFT;
      assign w_bits[i]   = (w_cmp < r_thr[i]);
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (r_count == c_CNT_MAX) begin
          w_state_nxt = S_LAST;
        end
      end
      S_LAST:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The final bit is registered on the RUN->LAST edge together with done,
  // so LAST only has to drop valid/done on its way out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count     <= '0;
      r_mode      <= 1'b0;
      r_u_out     <= '0;
      r_out_count <= '0;
      r_u_valid   <= 1'b0;
      r_done      <= 1'b0;
      for (int i = 0; i < CH; i++) begin
        r_thr[i] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_mode  <= bus.mode;
        r_count <= '0;
        for (int i = 0; i < CH; i++) begin
          r_thr[i] <= w_thr_in[i];
        end
      end
      if (r_state == S_RUN) begin
        r_u_out     <= w_bits;
        r_out_count <= r_count;
        r_u_valid   <= 1'b1;
        if (r_count == c_CNT_MAX) begin
          r_done <= 1'b1;
        end else begin
          r_count <= r_count + c_CNT_ONE;
        end
      end else begin
        r_u_valid <= 1'b0;
        r_done    <= 1'b0;
      end
    end
  end

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.u_valid   = r_u_valid;
  assign bus.u_out     = r_u_out;
  assign bus.out_count = r_out_count;
  assign bus.done      = r_done;

`ifdef ONES_COUNT_EN
  localparam logic [LEN_W:0] c_ONES_ONE = (LEN_W+1)'(1);

  logic [LEN_W:0] r_ones [CH];

  // Counted as bits are registered so the total is already final in the done cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < CH; i++) begin
        r_ones[i] <= '0;
      end
    end else if (w_accept) begin
      for (int i = 0; i < CH; i++) begin
        r_ones[i] <= '0;
      end
    end else if (r_state == S_RUN) begin
      for (int i = 0; i < CH; i++) begin
        if (w_bits[i]) begin
          r_ones[i] <= r_ones[i] + c_ONES_ONE;
        end
      end
    end
  end

  generate
    for (genvar i = 0; i < CH; i++) begin : g_ones
      assign bus.ones_cnt[i*(LEN_W+1) +: (LEN_W+1)] = r_ones[i];
    end
  endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_unary_gen_mc.sv
`default_nettype none
// ============================================================================
// Module  : tb_unary_gen_mc
// Brief   : Scoreboard bench for unary_gen_mc: default config (DUT A) and a
//           LEN_W == DATA_W config (DUT B). ONES_COUNT_EN adds ones_cnt checks.
// Revision: 1.0 - initial release
// ============================================================================
module tb_unary_gen_mc;

  localparam int DW  = 8;
  localparam int LW  = 10;
  localparam int NCH = 4;
  localparam int N   = 1 << LW;
  localparam int BDW = 8;
  localparam int BLW = 8;
  localparam int BCH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;

  unary_gen_mc_if #(.DATA_W(DW),  .LEN_W(LW),  .CH(NCH)) ifa ();
  unary_gen_mc_if #(.DATA_W(BDW), .LEN_W(BLW), .CH(BCH)) ifb ();

  unary_gen_mc #(.DATA_W(DW),  .LEN_W(LW),  .CH(NCH)) dut_a (.clk(clk), .reset(rst_a), .bus(ifa));
  unary_gen_mc #(.DATA_W(BDW), .LEN_W(BLW), .CH(BCH)) dut_b (.clk(clk), .reset(rst_b), .bus(ifb));

  int     n_cmp = 0;
  int     n_bad = 0;
  longint cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic int bitrev(input int v, input int w);
    int r = 0;
    for (int b = 0; b < w; b++) begin
      if (((v >> b) & 1) != 0) r = r | (1 << (w - 1 - b));
    end
    return r;
  endfunction

  // ---------------- DUT A reference model ----------------
  typedef struct {
    longint                  cyc;
    int                      idx;
    logic [NCH-1:0]          bits;
    logic                    done;
    logic [NCH*(LW+1)-1:0]   ones;
  } exp_t;

  exp_t   qa[$];
  longint a_busy_end = -1;
  int     last_idx   = 0;
  logic [NCH-1:0] last_bits = '0;

  // Model of one frame accepted at edge t: bit k appears in the sample after edge t+1+k.
  task automatic push_frame_a(input longint t, input logic [NCH*DW-1:0] sc, input logic md);
    int   thr [NCH];
    exp_t e;
    for (int c = 0; c < NCH; c++) thr[c] = int'(sc[c*DW +: DW]) * (1 << (LW - DW));
    for (int k = 0; k < N; k++) begin
      int pos;
      pos    = md ? bitrev(k, LW) : k;
      e.cyc  = t + 1 + k;
      e.idx  = k;
      e.done = (k == N - 1);
      e.ones = '0;
      for (int c = 0; c < NCH; c++) begin
        e.bits[c] = (pos < thr[c]);
        e.ones[c*(LW+1) +: (LW+1)] = (LW+1)'(thr[c]);
      end
      qa.push_back(e);
    end
  endtask

  // Predictor: frames are accepted only when idle; also checks busy.
  always @(negedge clk) begin
    if (rst_a) begin
      chk("a_busy", ifa.busy, (cyc <= a_busy_end));
      if (cyc > a_busy_end && ifa.start === 1'b1) begin
        push_frame_a(cyc + 1, ifa.scalars, ifa.mode);
        a_busy_end = cyc + 1 + N;
      end
    end
  end

  // Monitor A
  always @(negedge clk) begin
    if (rst_a) begin
      if (ifa.u_valid === 1'b1) begin
        if (qa.size() == 0) begin
          chk("a_unexpected_valid", 1, 0);
        end else begin
          exp_t e;
          e = qa.pop_front();
          chk("a_bit_cycle", cyc, e.cyc);
          chk("a_out_count", ifa.out_count, e.idx);
          chk("a_u_out", ifa.u_out, e.bits);
          chk("a_done", ifa.done, e.done);
`ifdef ONES_COUNT_EN
          if (e.done) chk("a_ones_cnt", ifa.ones_cnt, e.ones);
`endif
          last_idx  = e.idx;
          last_bits = e.bits;
        end
      end else begin
        chk("a_done_without_valid", ifa.done, 0);
        chk("a_hold_out_count", ifa.out_count, last_idx);
        chk("a_hold_u_out", ifa.u_out, last_bits);
      end
    end
  end

  task automatic wait_idle_a();
    int k = 0;
    while (ifa.busy !== 1'b0 && k < 3000) begin
      @(posedge clk); #1;
      k++;
    end
    if (ifa.busy !== 1'b0) chk("a_idle_timeout", 1, 0);
  endtask

  task automatic run_frame_a(input logic [NCH*DW-1:0] sc, input logic md, input bit disturb);
    wait_idle_a();
    ifa.scalars = sc;
    ifa.mode    = md;
    ifa.start   = 1'b1;
    @(posedge clk); #1;
    ifa.start = 1'b0;
    if (disturb) begin
      repeat (N) begin
        @(posedge clk); #1;
        ifa.scalars = {$urandom, $urandom};
        ifa.mode    = 1'($urandom);
        ifa.start   = 1'($urandom);
      end
      @(posedge clk); #1;
      ifa.start = 1'b0;
    end
  endtask

  task automatic reset_zero_checks_a(input string tag);
    chk({tag, "_busy"},      ifa.busy, 0);
    chk({tag, "_u_valid"},   ifa.u_valid, 0);
    chk({tag, "_done"},      ifa.done, 0);
    chk({tag, "_u_out"},     ifa.u_out, 0);
    chk({tag, "_out_count"}, ifa.out_count, 0);
  endtask

  // ---------------- DUT B (LEN_W == DATA_W) ----------------
  logic [BCH*BDW-1:0] qb[$];
  int cb [BCH];
  bit b_done = 1'b0;

  always @(negedge clk) begin
    if (!rst_b) begin
      for (int c = 0; c < BCH; c++) cb[c] = 0;
    end else if (ifb.u_valid === 1'b1) begin
      for (int c = 0; c < BCH; c++) cb[c] += int'(ifb.u_out[c]);
      if (ifb.done === 1'b1) begin
        if (qb.size() == 0) begin
          chk("b_unexpected_done", 1, 0);
        end else begin
          logic [BCH*BDW-1:0] s;
          s = qb.pop_front();
          for (int c = 0; c < BCH; c++) begin
            chk("b_ones", cb[c], s[c*BDW +: BDW]);
`ifdef ONES_COUNT_EN
            chk("b_ones_cnt", ifb.ones_cnt[c*(BLW+1) +: (BLW+1)], s[c*BDW +: BDW]);
`endif
          end
        end
        for (int c = 0; c < BCH; c++) cb[c] = 0;
      end
    end
  end

  initial begin
    rst_b = 1'b0;
    ifb.start = 1'b0;
    ifb.scalars = '0;
    ifb.mode = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_b = 1'b1;
    for (int f = 0; f < 4; f++) begin
      logic [BCH*BDW-1:0] s;
      int k;
      k = 0;
      while (ifb.busy !== 1'b0 && k < 1000) begin
        @(posedge clk); #1;
        k++;
      end
      if (ifb.busy !== 1'b0) chk("b_idle_timeout", 1, 0);
      s = {8'($urandom), 8'd200};
      if (f == 3) s = {8'd255, 8'd0};
      ifb.scalars = s;
      ifb.mode    = 1'(f);
      ifb.start   = 1'b1;
      qb.push_back(s);
      @(posedge clk); #1;
      ifb.start = 1'b0;
    end
    begin
      int k;
      k = 0;
      while ((ifb.busy !== 1'b0 || qb.size() != 0) && k < 1000) begin
        @(posedge clk); #1;
        k++;
      end
    end
    chk("b_queue_drained", qb.size(), 0);
    b_done = 1'b1;
  end

  // ---------------- main sequence for DUT A ----------------
  initial begin
    rst_a = 1'b0;
    ifa.start = 1'b0;
    ifa.scalars = '0;
    ifa.mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_zero_checks_a("reset");
    @(posedge clk); #1;
    rst_a = 1'b1;

    run_frame_a({8'd255, 8'd128, 8'd1, 8'd0}, 1'b0, 1'b0);
    run_frame_a({8'd255, 8'd128, 8'd1, 8'd0}, 1'b1, 1'b0);
    for (int f = 0; f < 3; f++) run_frame_a({$urandom, $urandom}, 1'($urandom), 1'b1);

    // start held high: frames follow each other with one idle cycle
    wait_idle_a();
    ifa.start = 1'b1;
    for (int j = 0; j < 3 * (N + 2) - 20; j++) begin
      @(posedge clk); #1;
      ifa.scalars = {$urandom, $urandom};
      ifa.mode    = 1'($urandom);
    end
    ifa.start = 1'b0;

    // asynchronous reset in the middle of a frame
    run_frame_a({$urandom, $urandom}, 1'b1, 1'b0);
    repeat (300) @(posedge clk);
    #2 rst_a = 1'b0;
    #1;
    reset_zero_checks_a("midreset");
    qa.delete();
    a_busy_end = -1;
    last_idx   = 0;
    last_bits  = '0;
    @(posedge clk); #1;
    reset_zero_checks_a("midreset_hold");
    rst_a = 1'b1;

    run_frame_a({8'd7, 8'd255, 8'd0, 8'd129}, 1'b0, 1'b0);
    wait_idle_a();
    @(posedge clk); #1;
    chk("a_queue_drained", qa.size(), 0);

    begin
      int k;
      k = 0;
      while (!b_done && k < 20000) begin
        @(posedge clk); #1;
        k++;
      end
      if (!b_done) chk("b_finish_timeout", 1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
